arm_barrel_shifter: RTL and testbench

- Registered ARM-style operand-2 barrel shifter for the CPU datapath.
- Takes a 32-bit value, a 2-bit shift type and a 5-bit immediate shift amount, plus the current C flag.
- Produces the shifted operand and shifter carry-out for the ALU/flag logic one clock later.
- Implements the ARM immediate-shift encodings, including the #0 special cases: LSR #32, ASR #32 and RRX.

---
 rtl/arm_barrel_shifter.sv | 152 +++++++++++++++
 tb/tb_arm_barrel_shifter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arm_barrel_shifter.sv
// rtl/arm_barrel_shifter.sv - registered ARM operand-2 barrel shifter, 1-cycle latency.
// Optional register-specified shift amount (Rs[7:0]) enabled by BARREL_SHIFTER_REG_SHIFT_EN.
`ifndef WordWidth
`define WordWidth 32
`endif
`ifndef LogicalLeftShift
`define LogicalLeftShift 2'b00
`endif
`ifndef LogicalRightShift
`define LogicalRightShift 2'b01
`endif
`ifndef ArithmeticRightShift
`define ArithmeticRightShift 2'b10
`endif
`ifndef RotateRightShift
`define RotateRightShift 2'b11
`endif

module arm_barrel_shifter (
  input  logic                  in_Clk,
  input  logic                  in_Reset,
  input  logic                  in_Valid,
  input  logic [`WordWidth-1:0] in_Val,
  input  logic [1:0]            in_Shift_type,
  input  logic [4:0]            in_Shift_imm,
  input  logic                  in_C_flag,
`ifdef BARREL_SHIFTER_REG_SHIFT_EN
  input  logic                  in_Shift_by_reg,
  input  logic [7:0]            in_Shift_reg_amt,
`endif
  output logic [`WordWidth-1:0] out_Op2,
  output logic                  out_Carry,
  output logic                  out_Valid
);
  localparam int W = `WordWidth;

  logic [4:0]     amt;
  logic           is_lsl;
  logic           sign;
  logic [W-1:0]   rev_in;
  logic [W-1:0]   x;
  logic [2*W-1:0] ext;
  logic           core_c;
  logic [W-1:0]   core_op;
  logic [W-1:0]   op2_d, op2_q;
  logic           carry_d, carry_q;
  logic           valid_q;

  assign sign   = in_Val[W-1];
  assign is_lsl = (in_Shift_type == `LogicalLeftShift);
  assign rev_in = {<<{in_Val}};

`ifdef BARREL_SHIFTER_REG_SHIFT_EN
  assign amt = in_Shift_by_reg ? in_Shift_reg_amt[4:0] : in_Shift_imm;
`else
  assign amt = in_Shift_imm;
`endif

  // Five power-of-two right-shift stages; LSL runs through them bit-reversed.
  // The carry tracks the last bit shifted out by the most recent active stage.
  always_comb begin
    x      = is_lsl ? rev_in : in_Val;
    core_c = in_C_flag;
    ext    = '0;
    for (int k = 0; k < 5; k++) begin
      if (amt[k]) begin
        unique case (in_Shift_type)
          `ArithmeticRightShift: ext = {{W{sign}}, x};
          `RotateRightShift:     ext = {x, x};
          default:               ext = {{W{1'b0}}, x};
        endcase
        core_c = x[(1 << k) - 1];
        x      = W'(ext >> (1 << k));
      end
    end
  end

  assign core_op = is_lsl ? {<<{x}} : x;

  always_comb begin
    op2_d   = core_op;
    carry_d = core_c;
`ifdef BARREL_SHIFTER_REG_SHIFT_EN
    if (in_Shift_by_reg) begin
      if (in_Shift_reg_amt == 8'd0) begin
        op2_d   = in_Val;
        carry_d = in_C_flag;
      end else if (in_Shift_reg_amt[7:5] != 3'd0) begin
        unique case (in_Shift_type)
          `LogicalLeftShift: begin
            op2_d   = '0;
            carry_d = (in_Shift_reg_amt == 8'd32) & in_Val[0];
          end
          `LogicalRightShift: begin
            op2_d   = '0;
            carry_d = (in_Shift_reg_amt == 8'd32) & sign;
          end
          `ArithmeticRightShift: begin
            op2_d   = {W{sign}};
            carry_d = sign;
          end
          default: begin
            // Rotation by a multiple of 32 leaves the value intact.
            if (in_Shift_reg_amt[4:0] == 5'd0) begin
              op2_d   = in_Val;
              carry_d = sign;
            end
          end
        endcase
      end
    end else
`endif
    if (in_Shift_imm == 5'd0) begin
      unique case (in_Shift_type)
        `LogicalRightShift: begin
          op2_d   = '0;
          carry_d = sign;
        end
        `ArithmeticRightShift: begin
          op2_d   = {W{sign}};
          carry_d = sign;
        end
        `RotateRightShift: begin
          op2_d   = {in_C_flag, in_Val[W-1:1]};
          carry_d = in_Val[0];
        end
        default: begin
          op2_d   = in_Val;
          carry_d = in_C_flag;
        end
      endcase
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      op2_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_Valid;
      if (in_Valid) begin
        op2_q   <= op2_d;
        carry_q <= carry_d;
      end
    end
  end

  assign out_Op2   = op2_q;
  assign out_Carry = carry_q;
  assign out_Valid = valid_q;
endmodule

// File: tb/tb_arm_barrel_shifter.sv
// tb/tb_arm_barrel_shifter.sv - self-checking bench for arm_barrel_shifter.
// Covers BARREL_SHIFTER_REG_SHIFT_EN vectors when that macro is defined.
module tb_arm_barrel_shifter;
  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic [31:0] val;
  logic [1:0]  typ;
  logic [4:0]  imm;
  logic        cf;
  logic        by_reg;
  logic [7:0]  ramt;
  logic [31:0] op2;
  logic        carry;
  logic        vout;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_op;
  logic        m_c;
  logic        m_v;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  arm_barrel_shifter dut (
    .in_Clk          (clk),
    .in_Reset        (rst),
    .in_Valid        (vin),
    .in_Val          (val),
    .in_Shift_type   (typ),
    .in_Shift_imm    (imm),
    .in_C_flag       (cf),
`ifdef BARREL_SHIFTER_REG_SHIFT_EN
    .in_Shift_by_reg (by_reg),
    .in_Shift_reg_amt(ramt),
`endif
    .out_Op2         (op2),
    .out_Carry       (carry),
    .out_Valid       (vout)
  );

  // Returns {carry, op2} straight from the ARM shifter rules.
  function automatic logic [32:0] model(input logic [31:0] v, input logic [1:0] t,
                                        input logic [4:0] n, input logic c,
                                        input logic br, input logic [7:0] r);
    int a;
    logic signed [31:0] sv;
    logic [31:0] o;
    sv = v;
    if (br) begin
      a = int'(r);
      if (a == 0) return {c, v};
      if (a >= 32) begin
        case (t)
          T_LSL: return {(a == 32) ? v[0] : 1'b0, 32'd0};
          T_LSR: return {(a == 32) ? v[31] : 1'b0, 32'd0};
          T_ASR: return {v[31], {32{v[31]}}};
          default: begin
            a = a % 32;
            if (a == 0) return {v[31], v};
          end
        endcase
      end
    end else begin
      a = int'(n);
      if (a == 0) begin
        case (t)
          T_LSL: return {c, v};
          T_LSR: return {v[31], 32'd0};
          T_ASR: return {v[31], {32{v[31]}}};
          default: return {v[0], c, v[31:1]};
        endcase
      end
    end
    case (t)
      T_LSL: return {v[32 - a], v << a};
      T_LSR: return {v[a - 1], v >> a};
      T_ASR: begin
        o = sv >>> a;
        return {v[a - 1], o};
      end
      default: begin
        o = (v >> a) | (v << (32 - a));
        return {o[31], o};
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_op = 32'd0;
      m_c  = 1'b0;
      m_v  = 1'b0;
    end else begin
      m_v = vin;
      if (vin) {m_c, m_op} = model(val, typ, imm, cf, by_reg, ramt);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model valid", {31'd0, vout}, {31'd0, m_v});
      chk("model op2", op2, m_op);
      chk("model carry", {31'd0, carry}, {31'd0, m_c});
    end
  end

  task automatic issue(input logic [1:0] t, input logic [31:0] v, input logic [4:0] n,
                       input logic c, input logic br, input logic [7:0] r);
    vin = 1'b1; typ = t; val = v; imm = n; cf = c; by_reg = br; ramt = r;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] eop, input logic ec);
    chk({name, " op2"}, op2, eop);
    chk({name, " carry"}, {31'd0, carry}, {31'd0, ec});
    chk({name, " valid"}, {31'd0, vout}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; val = '0; typ = '0; imm = '0; cf = 1'b0;
    by_reg = 1'b0; ramt = '0;
    repeat (2) @(negedge clk);
    chk("reset op2", op2, 32'd0);
    chk("reset carry", {31'd0, carry}, 32'd0);
    chk("reset valid", {31'd0, vout}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    issue(T_LSL, 32'd2, 5'd1, 1'b0, 1'b0, 8'd0); lit("lsl1", 32'd4, 1'b0);
    issue(T_LSL, 32'd2, 5'd0, 1'b1, 1'b0, 8'd0); lit("lsl0", 32'd2, 1'b1);
    issue(T_LSR, 32'd2, 5'd1, 1'b0, 1'b0, 8'd0); lit("lsr1", 32'd1, 1'b0);
    issue(T_LSR, 32'd2, 5'd0, 1'b0, 1'b0, 8'd0); lit("lsr32a", 32'd0, 1'b0);
    issue(T_LSR, 32'h8000_0000, 5'd0, 1'b0, 1'b0, 8'd0); lit("lsr32b", 32'd0, 1'b1);
    issue(T_ASR, 32'd13244, 5'd10, 1'b1, 1'b0, 8'd0); lit("asr10", 32'd12, 1'b1);
    issue(T_ASR, 32'd4290000000, 5'd0, 1'b0, 1'b0, 8'd0); lit("asr32", 32'hFFFF_FFFF, 1'b1);
    issue(T_ROR, 32'd200, 5'd4, 1'b0, 1'b0, 8'd0); lit("ror4", 32'h8000_000C, 1'b1);
    issue(T_ROR, 32'd200, 5'd0, 1'b0, 1'b0, 8'd0); lit("rrx0", 32'h0000_0064, 1'b0);
    issue(T_ROR, 32'd200, 5'd0, 1'b1, 1'b0, 8'd0); lit("rrx1", 32'h8000_0064, 1'b0);
    issue(T_LSL, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 8'd0); lit("lsl31", 32'h8000_0000, 1'b0);

    vin = 1'b0;
    @(negedge clk);
    chk("hold valid", {31'd0, vout}, 32'd0);
    chk("hold op2", op2, 32'h8000_0000);
    chk("hold carry", {31'd0, carry}, 32'd0);

    for (int i = 0; i < 48; i++)
      issue(2'(i % 4), $urandom, 5'((i * 7) % 32), 1'($urandom_range(0, 1)), 1'b0, 8'd0);

    issue(T_ROR, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 8'd0);
    rst = 1'b1; vin = 1'b1;
    @(negedge clk);
    chk("midreset op2", op2, 32'd0);
    chk("midreset carry", {31'd0, carry}, 32'd0);
    chk("midreset valid", {31'd0, vout}, 32'd0);
    rst = 1'b0;

`ifdef BARREL_SHIFTER_REG_SHIFT_EN
    issue(T_LSL, 32'd1, 5'd3, 1'b0, 1'b1, 8'd32); lit("reg lsl32", 32'd0, 1'b1);
    issue(T_LSR, 32'h8000_0000, 5'd3, 1'b1, 1'b1, 8'd40); lit("reg lsr40", 32'd0, 1'b0);
    issue(T_ROR, 32'h8000_0001, 5'd0, 1'b0, 1'b1, 8'd32); lit("reg ror32", 32'h8000_0001, 1'b1);
    issue(T_ASR, 32'h8000_1234, 5'd7, 1'b1, 1'b1, 8'd0); lit("reg r0", 32'h8000_1234, 1'b1);
    issue(T_ASR, 32'h8000_0000, 5'd0, 1'b0, 1'b1, 8'd200); lit("reg asr200", 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 48; i++)
      issue(2'(i % 4), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)));
`endif

    vin = 1'b0;
    by_reg = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
